lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//   Receive-side partner of the 8-bit Fibonacci LFSR generator (taps 8,6,5,4).
//   Consumes the generator's serial bit stream, self-synchronises by loading 8 received bits
//   as its seed, confirms lock, then predicts each following bit.
//   Counts mismatches and declares loss of lock on an excessive error rate.
//   Used as a link/BIST pattern checker at the far end of a serial path.
// PARAMETERS
//   CNT_W       16  width of saturating error counter o_err_cnt
//   LOCK_GOOD   16  consecutive matching bits needed in VERIFY before lock (>=1)
//   WINDOW      64  bits per error-rate window in LOCKED (>=2)
//   ERR_THRESH   4  errors within one window that cause loss of lock (1..WINDOW)
// PORTS
//   clk          in   1      clock, all state on posedge
//   rst          in   1      reset, asynchronous, active-high
//   i_valid      in   1      i_bit valid this cycle; no state advances when low
//   i_bit        in   1      received serial bit
//   i_clr_cnt    in   1      synchronous clear of o_err_cnt
//   o_locked     out  1      high while in LOCKED
//   o_err        out  1      1-cycle pulse: mismatch accepted in LOCKED
//   o_lock_lost  out  1      1-cycle pulse: LOCKED -> LOAD on error threshold
//   o_err_cnt    out  CNT_W  total mismatches in LOCKED, saturating at all-ones
//   o_state      out  2      0=LOAD 1=VERIFY 2=LOCKED (3 unused)
// BEHAVIOUR
//   Reset: state=LOAD, shift reg s=0, all counters 0, all outputs 0. Applies immediately.
//     Takes effect mid-operation too; discards any partial load or lock.
//   Outputs are registered; each reflects the edge that accepted the bit.
//   Prediction: p = s[7]^s[5]^s[4]^s[3]. The generator emits its new feedback bit each step.
//   LOAD: each valid bit: s <= {s[6:0], i_bit}. The first received bit ends in s[7].
//     After the 8th valid bit, go to VERIFY if the new s != 0.
//     If the new s == 0 (lock-up pattern), restart the 8-bit load.
//   VERIFY: each valid bit: compare i_bit with p, then s <= {s[6:0], p}.
//     Match: good_cnt++. When it reaches LOCK_GOOD -> LOCKED, same edge sets o_locked.
//     Mismatch: -> LOAD, good_cnt=0, bit count=0. No o_err; o_err_cnt is untouched.
//   LOCKED: each valid bit: s <= {s[6:0], p}. The predicted bit is always shifted in,
//     so errors never corrupt s.
//     Mismatch: o_err=1 for that cycle; o_err_cnt++ (saturate); win_err++.
//     win_bits++ per valid bit.
//     Accepting the WINDOW-th bit clears win_bits and win_err on the same edge.
//     If win_err+mismatch reaches ERR_THRESH: -> LOAD, o_lock_lost=1 for that cycle,
//       o_locked=0. Load restarts with the next valid bit.
//       This check has priority over window rollover on the same bit.
//   i_clr_cnt: the counter is cleared first, then any same-cycle error is added
//     (result 1). State, lock and window counters are unaffected.
//   o_err_cnt holds its value across lock loss. It is cleared only by rst or i_clr_cnt.
//   i_valid low: all state, counters and s hold; o_err and o_lock_lost are 0.
//   Latency: a clean stream locks on the edge accepting valid bit 8+LOCK_GOOD (default 24).
// TESTING
//   1 rst pulse mid-stream -> o_state=0, o_locked=0, o_err_cnt=0 immediately (async).
//   2 Generator seed 8'hA5, clean stream, i_valid=1
//     -> o_state=1 after bit 8; o_locked=1 after bit 24; o_err never asserts over 1000 bits.
//   3 Locked; invert one bit -> o_err one-cycle pulse, o_err_cnt=1, o_locked stays 1.
//     Next bits match: the error does not propagate.
//   4 Locked; invert 4 bits within 64 -> o_lock_lost pulse on the 4th error; o_err_cnt=4.
//     Relocks 24 bits later.
//     Invert 3 bits per 64-bit window -> never loses lock.
//   5 All-zero input stream -> state stays LOAD forever.
//     Random i_valid gaps (~50%) on a clean stream -> same lock point in valid bits.
//   6 i_clr_cnt with a simultaneous error -> o_err_cnt=1.
//     With CNT_W=4 and 20 errors -> o_err_cnt=15 (saturated).

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for an 8-bit Fibonacci LFSR stream (taps 8,6,5,4): self-seeds, verifies, tracks errors.
// Latency: outputs are registered and reflect the edge that accepted the bit; a clean stream locks on valid bit 8+LOCK_GOOD.
// Backpressure: none; i_valid low freezes all state and suppresses the o_err / o_lock_lost pulses.
module lfsr_checker #(
    parameter int CNT_W      = 16,
    parameter int LOCK_GOOD  = 16,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_lock_lost,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [1:0]       o_state
);

    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       s;
    logic [2:0]       bit_cnt;
    logic [GW-1:0]    good_cnt;
    logic [WW-1:0]    win_bits;
    logic [EW-1:0]    win_err;

    logic             pred;
    logic             mismatch;
    logic [7:0]       s_load;
    logic [7:0]       s_pred;
    logic             err_hit;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    assign pred     = s[7] ^ s[5] ^ s[4] ^ s[3];
    assign mismatch = i_bit ^ pred;
    assign s_load   = {s[6:0], i_bit};
    assign s_pred   = {s[6:0], pred};
    assign err_hit  = i_valid && (state == ST_LOCKED) && mismatch;

    // Clear wins over the old value, but a same-cycle error still counts.
    assign cnt_base = i_clr_cnt ? '0 : o_err_cnt;
    assign cnt_next = (err_hit && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;

    assign o_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            s           <= '0;
            bit_cnt     <= '0;
            good_cnt    <= '0;
            win_bits    <= '0;
            win_err     <= '0;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
            o_lock_lost <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            o_err       <= err_hit;
            o_lock_lost <= 1'b0;
            o_err_cnt   <= cnt_next;
            if (i_valid) begin
                case (state)
                    ST_LOAD: begin
                        s       <= s_load;
                        bit_cnt <= bit_cnt + 3'd1;
                        // An all-zero seed would lock the predictor up; keep loading instead.
                        if (bit_cnt == 3'd7 && s_load != 8'd0) begin
                            state    <= ST_VERIFY;
                            good_cnt <= '0;
                        end
                    end
                    ST_VERIFY: begin
                        s <= s_pred;
                        if (mismatch) begin
                            state    <= ST_LOAD;
                            good_cnt <= '0;
                            bit_cnt  <= '0;
                        end else if (good_cnt == GW'(LOCK_GOOD - 1)) begin
                            state    <= ST_LOCKED;
                            o_locked <= 1'b1;
                            good_cnt <= '0;
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Predicted bit is shifted in so a line error never corrupts s.
                        s <= s_pred;
                        if (mismatch && win_err == EW'(ERR_THRESH - 1)) begin
                            state       <= ST_LOAD;
                            o_locked    <= 1'b0;
                            o_lock_lost <= 1'b1;
                            bit_cnt     <= '0;
                            good_cnt    <= '0;
                            win_bits    <= '0;
                            win_err     <= '0;
                        end else if (win_bits == WW'(WINDOW - 1)) begin
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            win_bits <= win_bits + WW'(1);
                            if (mismatch) begin
                                win_err <= win_err + EW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= ST_LOAD;
                        o_locked <= 1'b0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed LFSR streams with error injection, expected outputs queued per bit.
module tb_lfsr_checker;

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        er;
        logic        ll;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, b1, c1, v2, b2, c2;
    logic        lk1, er1, ll1, lk2, er2, ll2;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;
    logic [1:0]  st1, st2;

    always #5 clk = ~clk;

    lfsr_checker #(.CNT_W(16), .LOCK_GOOD(16), .WINDOW(64), .ERR_THRESH(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .i_bit(b1), .i_clr_cnt(c1),
        .o_locked(lk1), .o_err(er1), .o_lock_lost(ll1), .o_err_cnt(cnt1), .o_state(st1)
    );

    lfsr_checker #(.CNT_W(4), .LOCK_GOOD(16), .WINDOW(64), .ERR_THRESH(64)) u_dut2 (
        .clk(clk), .rst(rst), .i_valid(v2), .i_bit(b2), .i_clr_cnt(c2),
        .o_locked(lk2), .o_err(er2), .o_lock_lost(ll2), .o_err_cnt(cnt2), .o_state(st2)
    );

    exp_t       q1[$];
    exp_t       q2[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] gen[2];
    int         phase[2];
    int         exp_cnt[2];
    int         cmax[2];

    function automatic exp_t got(input int d);
        exp_t a;
        if (d == 0) a = '{st: st1, lk: lk1, er: er1, ll: ll1, cnt: cnt1};
        else        a = '{st: st2, lk: lk2, er: er2, ll: ll2, cnt: {12'd0, cnt2}};
        return a;
    endfunction

    task automatic cmp(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d lk=%0b err=%0b lost=%0b cnt=%0d, expected st=%0d lk=%0b err=%0b lost=%0b cnt=%0d",
                     name, act.st, act.lk, act.er, act.ll, act.cnt, exp.st, exp.lk, exp.er, exp.ll, exp.cnt);
        end
    endtask

    task automatic pop_check(input int d);
        exp_t e;
        if ((d == 0 && q1.size() == 0) || (d == 1 && q2.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow dut%0d: output with no expected entry", d + 1);
        end else begin
            if (d == 0) e = q1.pop_front();
            else        e = q2.pop_front();
            cmp(d == 0 ? "dut1_bit" : "dut2_bit", got(d), e);
        end
    endtask

    // Monitor: every accepted bit produces one registered response to compare.
    initial begin
        logic a1, a2;
        forever begin
            @(posedge clk);
            a1 = v1;
            a2 = v2;
            #1;
            if (a1 === 1'b1) pop_check(0);
            if (a2 === 1'b1) pop_check(1);
        end
    end

    task automatic drive(input int d, input logic b, input logic clr);
        @(negedge clk);
        if (d == 0) begin
            v1 = 1'b1; b1 = b; c1 = clr; v2 = 1'b0; c2 = 1'b0;
        end else begin
            v2 = 1'b1; b2 = b; c2 = clr; v1 = 1'b0; c1 = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; c1 = 1'b0; c2 = 1'b0;
    endtask

    // One generator bit (optionally inverted); expected state follows from bits since load start.
    task automatic send(input int d, input logic inv, input logic lost, input logic clr);
        logic fb;
        exp_t e;
        fb     = gen[d][7] ^ gen[d][5] ^ gen[d][4] ^ gen[d][3];
        gen[d] = {gen[d][6:0], fb};
        phase[d]++;
        if (clr) exp_cnt[d] = 0;
        if (inv && exp_cnt[d] < cmax[d]) exp_cnt[d]++;
        e.er  = inv;
        e.cnt = 16'(exp_cnt[d]);
        if (lost) begin
            e.st = 2'd0; e.lk = 1'b0; e.ll = 1'b1;
            phase[d] = 0;
        end else begin
            e.st = (phase[d] < 8) ? 2'd0 : (phase[d] < 24) ? 2'd1 : 2'd2;
            e.lk = (phase[d] >= 24);
            e.ll = 1'b0;
        end
        if (d == 0) q1.push_back(e);
        else        q2.push_back(e);
        drive(d, fb ^ inv, clr);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; c1 = 1'b0; c2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp({name, "_dut1"}, got(0), '0);
        cmp({name, "_dut2"}, got(1), '0);
        #1 rst = 1'b0;
        phase[0] = 0; phase[1] = 0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
    endtask

    initial begin
        exp_t z;
        rst = 1'b0;
        v1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v2 = 1'b0; b2 = 1'b0; c2 = 1'b0;
        gen[0] = 8'hA5; gen[1] = 8'h3C;
        cmax[0] = 65535; cmax[1] = 15;
        z = '0;

        do_reset("reset_init");

        // Clean stream: VERIFY after bit 8, LOCKED after bit 24, no errors over 1000 bits.
        repeat (1000) send(0, 1'b0, 1'b0, 1'b0);
        // Align to an error-window boundary (976 + 48 = 16 windows).
        repeat (48) send(0, 1'b0, 1'b0, 1'b0);

        // Single inverted bit: one error pulse, lock held, following bits match.
        for (int i = 0; i < 64; i++) send(0, i == 10, 1'b0, 1'b0);

        // Three errors per window, including the last bit of a window, never lose lock.
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++) send(0, (i == 5 || i == 30 || i == 63), 1'b0, 1'b0);

        // Clear the counter, then four errors in one window: lock lost on the fourth.
        for (int i = 0; i <= 40; i++)
            send(0, (i == 2 || i == 9 || i == 20 || i == 40), i == 40, i == 0);
        // Relock 24 bits later, then stay clean.
        repeat (24 + 30) send(0, 1'b0, 1'b0, 1'b0);

        // Clear together with an error leaves a count of one.
        send(0, 1'b1, 1'b0, 1'b1);
        repeat (10) send(0, 1'b0, 1'b0, 1'b0);
        idle();

        do_reset("reset_mid_stream");

        // Random gaps in i_valid: lock point measured in valid bits is unchanged.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            send(0, 1'b0, 1'b0, 1'b0);
        end
        idle();

        do_reset("reset_before_zero");

        // All-zero input never leaves LOAD.
        repeat (40) begin
            q1.push_back(z);
            drive(0, 1'b0, 1'b0);
        end
        idle();

        // Narrow counter saturates at 15 after 20 errors.
        repeat (30) send(1, 1'b0, 1'b0, 1'b0);
        repeat (20) begin
            send(1, 1'b1, 1'b0, 1'b0);
            send(1, 1'b0, 1'b0, 1'b0);
        end
        repeat (5) send(1, 1'b0, 1'b0, 1'b0);
        idle();
        repeat (3) @(negedge clk);

        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q1.size(), q2.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
